vga_framebuffer_reader: RTL and testbench
=========================================

// Module: vga_framebuffer_reader
// PURPOSE
//  Read side of the camera frame buffer: scans 640x480@60 VGA timing and issues sequential read
//  addresses into the dual-port frame RAM. The same RAM is filled by the OV7670 capture path.
//  Returned RGB444 words go to the VGA pins, with hsync/vsync delayed to match the RAM read latency.
//  Sits between the frame RAM port B and the Nexys4 DDR VGA connector, in the 25 MHz pixel domain.
// PARAMETERS
//  H_ACTIVE    640  visible pixels per line
//  H_FP        16   horizontal front porch, pixels
//  H_SYNC      96   hsync pulse width, pixels
//  H_BP        48   horizontal back porch, pixels (line total 800)
//  V_ACTIVE    480  visible lines per frame
//  V_FP        10   vertical front porch, lines
//  V_SYNC      2    vsync pulse width, lines
//  V_BP        33   vertical back porch, lines (frame total 525)
//  RD_LATENCY  2    frame RAM read latency in cycles, from address to data; legal range 1..4
// PORTS
//  pclk         in   1   pixel clock, 25 MHz; only clock
//  rst_n        in   1   synchronous active-low reset
//  addr         out  19  frame RAM read address, linear 0..307199
//  din          in   12  frame RAM read data {R[3:0],G[3:0],B[3:0]}
//  vga_r        out  4   red
//  vga_g        out  4   green
//  vga_b        out  4   blue
//  vga_hsync    out  1   horizontal sync, active low
//  vga_vsync    out  1   vertical sync, active low
//  frame_start  out  1   one-cycle pulse when the counters enter h=0,v=0
// BEHAVIOUR
//  - Reset (rst_n=0 at a pclk edge): hcnt=0, vcnt=0, addr=0, the whole delay pipe cleared to blank.
//    Output values during reset: vga_r/g/b=0, vga_hsync=1, vga_vsync=1, frame_start=0.
//  - Reset asserted mid-frame aborts the frame. After release, scanning restarts at h=0,v=0 and
//    frame_start pulses on the first cycle after release.
//  - hcnt counts 0..799 and wraps to 0. vcnt increments when hcnt wraps, counts 0..524 and wraps to 0.
//  - Stage-0 (counter) decode:
//    active  = hcnt<640 && vcnt<480
//    hs_n    = !(656<=hcnt<=751)
//    vs_n    = !(490<=vcnt<=491)
//  - addr is registered. It holds 0 while vcnt>=480.
//  - addr increments by 1 after each cycle in which active=1, giving row-major, no-gap addressing.
//  - The last active pixel (639,479) reads address 307199. addr returns to 0 for the next frame.
//  - addr never exceeds 307199.
//  - Latency: the address issued in cycle N has its data in din at cycle N+RD_LATENCY.
//    vga_r/g/b are registered one cycle later, at N+RD_LATENCY+1.
//  - active, hs_n and vs_n pass through a shift register of depth RD_LATENCY+1. Sync and blank
//    therefore stay exactly aligned with their pixel at the pins.
//  - Pin outputs: vga_r=din[11:8], vga_g=din[7:4], vga_b=din[3:0] when delayed active=1, else 0.
//    Blanking forces 0 whatever din carries.
//  - frame_start is combinational from the registered counters: high when hcnt=0 && vcnt=0.
//    It is not delayed.
//  - Frame RAM is read every active cycle; there is no handshake or stall. The write side may
//    update the RAM at any time, so tearing is acceptable.
//  - Width rules: hcnt 10 b, vcnt 10 b, addr 19 b, all unsigned. Compare against the parameter sums;
//    no magic numbers in the RTL.
// STRUCTURE
//  - Shared package/header vga_timing_pkg holds: the eight timing values as localparams, plus
//    derived H_TOTAL=800, V_TOTAL=525, HS_START=656, HS_END=751, VS_START=490, VS_END=491,
//    FRAME_PIXELS=307200. The capture block reuses FRAME_PIXELS.
//  - Sub-module vga_timing_gen: owns hcnt/vcnt and outputs active, hs_n, vs_n, frame_start.
//  - This module keeps the address counter, the alignment shift register and the output registers.
// TESTING
//  1 Hold rst_n=0 for 5 cycles -> during reset hsync=1, vsync=1, rgb=0, addr=0. Release ->
//    frame_start=1 on cycle 1 only.
//  2 RAM model with RD_LATENCY=2 returning din=addr[11:0] -> pins show rgb=0x000 for address 0
//    at cycle 3. For the pixel at address 5, rgb=0x005 appears 3 cycles after addr=5.
//  3 Per line, count hsync -> low for exactly 96 cycles, first low at the pixel-clock cycle
//    matching hcnt=656+3. Per frame, vsync low for exactly 2 lines (1600 cycles); period 420000 cycles.
//  4 Run one full frame -> addr peaks at 307199 at (639,479), stays 0 through blanking, and the
//    next frame's first active cycle issues 0. No address is skipped or repeated (scoreboard).
//  5 Drive din=0xFFF constantly -> rgb=0 on every blank cycle and 0xF/0xF/0xF on all
//    307200 active cycles per frame.
//  6 Assert rst_n=0 for 1 cycle at (320,200) -> next cycle counters at (0,0), addr=0, pins blank,
//    frame_start pulses. The following frame is bit-identical to a clean-start frame.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and pipeline types for the frame buffer blocks.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;

    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START     = H_ACTIVE + H_FP;
    localparam int unsigned HS_END       = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START     = V_ACTIVE + V_FP;
    localparam int unsigned VS_END       = VS_START + V_SYNC - 1;
    localparam int unsigned FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned RGB_W  = 12;

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [RGB_W-1:0]  rgb_t;

    // Per-pixel control bits carried alongside the RAM read latency.
    typedef struct packed {
        logic active;
        logic hs_n;
        logic vs_n;
    } stage_t;

    localparam stage_t STAGE_BLANK = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

endpackage

// File: rtl/vga_framebuffer_reader_if.sv
// Frame RAM read port plus VGA pin bundle of the frame buffer reader.
interface vga_framebuffer_reader_if;
    import vga_timing_pkg::*;

    addr_t      addr;
    rgb_t       din;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       vga_hsync;
    logic       vga_vsync;
    logic       frame_start;

    modport master (
        output addr, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_start,
        input  din
    );

    modport slave (
        input  addr, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_start,
        output din
    );

endinterface

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical scan counters and their stage-0 decode.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned HActive = H_ACTIVE,
    parameter int unsigned HFp     = H_FP,
    parameter int unsigned HSync   = H_SYNC,
    parameter int unsigned HBp     = H_BP,
    parameter int unsigned VActive = V_ACTIVE,
    parameter int unsigned VFp     = V_FP,
    parameter int unsigned VSync   = V_SYNC,
    parameter int unsigned VBp     = V_BP
) (
    input  logic   pclk,
    input  logic   rst_n,
    output stage_t stage,
    output logic   v_visible,
    output logic   frame_start
);

    localparam cnt_t HActC   = cnt_t'(HActive);
    localparam cnt_t HLast   = cnt_t'(HActive + HFp + HSync + HBp - 1);
    localparam cnt_t HsFirst = cnt_t'(HActive + HFp);
    localparam cnt_t HsLast  = cnt_t'(HActive + HFp + HSync - 1);
    localparam cnt_t VActC   = cnt_t'(VActive);
    localparam cnt_t VLast   = cnt_t'(VActive + VFp + VSync + VBp - 1);
    localparam cnt_t VsFirst = cnt_t'(VActive + VFp);
    localparam cnt_t VsLast  = cnt_t'(VActive + VFp + VSync - 1);

    cnt_t hcnt;
    cnt_t vcnt;

    // Raster scan: hcnt wraps each line, vcnt steps on every hcnt wrap.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == HLast) begin
            hcnt <= '0;
            vcnt <= (vcnt == VLast) ? '0 : vcnt + cnt_t'(1);
        end else begin
            hcnt <= hcnt + cnt_t'(1);
        end
    end

    // Stage-0 decode straight off the counters; frame_start is held low while in reset.
    always_comb begin
        stage.active = (hcnt < HActC) && (vcnt < VActC);
        stage.hs_n   = !((hcnt >= HsFirst) && (hcnt <= HsLast));
        stage.vs_n   = !((vcnt >= VsFirst) && (vcnt <= VsLast));
        v_visible    = vcnt < VActC;
        frame_start  = rst_n && (hcnt == '0) && (vcnt == '0);
    end

endmodule

// File: rtl/vga_framebuffer_reader.sv
// Frame buffer read side: linear address generation, sync/blank alignment to RAM latency, pins.
module vga_framebuffer_reader
    import vga_timing_pkg::*;
#(
    parameter int unsigned HActive   = H_ACTIVE,
    parameter int unsigned HFp       = H_FP,
    parameter int unsigned HSync     = H_SYNC,
    parameter int unsigned HBp       = H_BP,
    parameter int unsigned VActive   = V_ACTIVE,
    parameter int unsigned VFp       = V_FP,
    parameter int unsigned VSync     = V_SYNC,
    parameter int unsigned VBp       = V_BP,
    // Frame RAM address-to-data latency; legal range 1..4.
    parameter int unsigned RdLatency = 2
) (
    input logic                      pclk,
    input logic                      rst_n,
    vga_framebuffer_reader_if.master bus
);

    localparam addr_t AddrLast = addr_t'(HActive * VActive - 1);

    stage_t stage0;
    logic   v_visible;
    logic   frame_start;

    vga_timing_gen #(
        .HActive (HActive),
        .HFp     (HFp),
        .HSync   (HSync),
        .HBp     (HBp),
        .VActive (VActive),
        .VFp     (VFp),
        .VSync   (VSync),
        .VBp     (VBp)
    ) u_timing (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .stage       (stage0),
        .v_visible   (v_visible),
        .frame_start (frame_start)
    );

    addr_t                  addr_q;
    stage_t [RdLatency:0]   pipe;
    rgb_t                   rgb_q;

    // Row-major address: step after each active pixel, park at 0 through vertical blanking.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (!v_visible) begin
            addr_q <= '0;
        end else if (stage0.active) begin
            addr_q <= (addr_q == AddrLast) ? '0 : addr_q + addr_t'(1);
        end
    end

    // Control bits ride RdLatency+1 stages so sync/blank land on the pins with their pixel.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            pipe <= {(RdLatency + 1){STAGE_BLANK}};
        end else begin
            pipe <= {pipe[RdLatency-1:0], stage0};
        end
    end

    // RAM data arrives RdLatency after its address; register it, forced to 0 when blanked.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= pipe[RdLatency-1].active ? bus.din : '0;
        end
    end

    // Pin mapping.
    always_comb begin
        bus.addr        = addr_q;
        bus.vga_r       = rgb_q[11:8];
        bus.vga_g       = rgb_q[7:4];
        bus.vga_b       = rgb_q[3:0];
        bus.vga_hsync   = pipe[RdLatency].hs_n;
        bus.vga_vsync   = pipe[RdLatency].vs_n;
        bus.frame_start = frame_start;
    end

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Self-checking bench: full-size 640x480 instance plus a shrunken-timing instance for frame-level
// behaviour, each fed by a behavioural frame RAM with the matching read latency.
module tb_vga_framebuffer_reader;
    import vga_timing_pkg::*;

    // Shrunken raster: 32 x 13 total, 20 x 6 visible, 416 cycles per frame.
    localparam int SHA = 20, SHF = 3, SHS = 5, SHB = 4;
    localparam int SVA = 6, SVF = 2, SVS = 2, SVB = 3;
    localparam int SLAT = 3, FLAT = 2;
    localparam int STOT = 32, SFRAME = 416, SPIX = 120;

    typedef struct packed {
        logic [18:0] addr;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
    } exp_t;

    logic pclk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;
    int   t = 0;
    int unsigned ram_mode = 0;
    int unsigned ram_seed = 0;

    always #20 pclk = ~pclk;

    vga_framebuffer_reader_if bus_f ();
    vga_framebuffer_reader_if bus_s ();

    vga_framebuffer_reader #(
        .RdLatency (FLAT)
    ) dut_full (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (bus_f)
    );

    vga_framebuffer_reader #(
        .HActive (SHA), .HFp (SHF), .HSync (SHS), .HBp (SHB),
        .VActive (SVA), .VFp (SVF), .VSync (SVS), .VBp (SVB),
        .RdLatency (SLAT)
    ) dut_small (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    // Frame RAM contents as a pure function of address.
    function automatic logic [11:0] ram_word(input logic [18:0] a);
        logic [31:0] x;
        if (ram_mode == 0) return a[11:0];
        if (ram_mode == 1) return 12'hFFF;
        x = ({13'd0, a} * 32'h9E3779B1) ^ ram_seed;
        return x[27:16];
    endfunction

    logic [18:0] hist_f [FLAT];
    logic [18:0] hist_s [SLAT];

    always @(posedge pclk) begin
        hist_f[0] <= bus_f.addr;
        hist_f[1] <= hist_f[0];
        hist_s[0] <= bus_s.addr;
        hist_s[1] <= hist_s[0];
        hist_s[2] <= hist_s[1];
    end

    always_comb bus_f.din = ram_word(hist_f[FLAT-1]);
    always_comb bus_s.din = ram_word(hist_s[SLAT-1]);

    // Expected outputs tt cycles after reset release (tt=0: counters at 0,0).
    function automatic exp_t model(input int tt, input int ha, hf, hsw, hb, va, vf, vsw, vb, lat);
        int htot, frame, p, h, v, q;
        exp_t e;
        htot = ha + hf + hsw + hb;
        frame = htot * (va + vf + vsw + vb);
        p = tt % frame;
        h = p % htot;
        v = p / htot;
        if (v >= va) e.addr = '0;
        else if (h < ha) e.addr = 19'(v * ha + h);
        else e.addr = 19'(((v + 1) * ha) % (ha * va));
        e.fs = (p == 0);
        if (tt < lat + 1) begin
            e.rgb = '0;
            e.hs = 1'b1;
            e.vs = 1'b1;
        end else begin
            q = (tt - lat - 1) % frame;
            h = q % htot;
            v = q / htot;
            e.rgb = (h < ha && v < va) ? ram_word(19'(v * ha + h)) : 12'h000;
            e.hs = !(h >= ha + hf && h < ha + hf + hsw);
            e.vs = !(v >= va + vf && v < va + vf + vsw);
        end
        return e;
    endfunction

    function automatic exp_t model_full(input int tt);
        return model(tt, int'(H_ACTIVE), int'(H_FP), int'(H_SYNC), int'(H_BP),
                     int'(V_ACTIVE), int'(V_FP), int'(V_SYNC), int'(V_BP), FLAT);
    endfunction

    function automatic exp_t model_small(input int tt);
        return model(tt, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, SLAT);
    endfunction

    function automatic exp_t obs_f();
        return {bus_f.addr, bus_f.vga_r, bus_f.vga_g, bus_f.vga_b,
                bus_f.vga_hsync, bus_f.vga_vsync, bus_f.frame_start};
    endfunction

    function automatic exp_t obs_s();
        return {bus_s.addr, bus_s.vga_r, bus_s.vga_g, bus_s.vga_b,
                bus_s.vga_hsync, bus_s.vga_vsync, bus_s.frame_start};
    endfunction

    // One clock: rst_n given here is what the next edge samples; returns mid-cycle for sampling.
    task automatic tick(input logic r);
        @(posedge pclk);
        if (!rst_n) t = 0;
        else t = t + 1;
        #1 rst_n = r;
        @(negedge pclk);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
        tick(1'b1);
    endtask

    task automatic test_reset();
        exp_t rexp;
        rexp = '{addr: '0, rgb: '0, hs: 1'b1, vs: 1'b1, fs: 1'b0};
        ram_mode = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0);
            vectors += 2;
            if (obs_f() !== rexp) begin
                errors++;
                $display("FAIL reset_full cyc=%0d got %h want %h", i, obs_f(), rexp);
            end
            if (obs_s() !== rexp) begin
                errors++;
                $display("FAIL reset_small cyc=%0d got %h want %h", i, obs_s(), rexp);
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b1);
            vectors += 3;
            if (bus_f.frame_start !== logic'(i == 0)) begin
                errors++;
                $display("FAIL release_fs_full cyc=%0d got %b want %b", i, bus_f.frame_start, i == 0);
            end
            if (bus_s.frame_start !== logic'(i == 0)) begin
                errors++;
                $display("FAIL release_fs_small cyc=%0d got %b want %b", i, bus_s.frame_start, i == 0);
            end
            if (bus_f.addr !== 19'(i)) begin
                errors++;
                $display("FAIL release_addr cyc=%0d got %0d want %0d", i, bus_f.addr, i);
            end
        end
    endtask

    task automatic test_pipeline();
        exp_t e;
        logic [11:0] rgb;
        ram_mode = 0;
        do_reset(2);
        for (int i = 0; i < 40; i++) begin
            rgb = {bus_f.vga_r, bus_f.vga_g, bus_f.vga_b};
            e = model_full(t);
            vectors++;
            if (rgb !== e.rgb) begin
                errors++;
                $display("FAIL pipe_rgb t=%0d got %h want %h", t, rgb, e.rgb);
            end
            if (t == 5) begin
                vectors++;
                if (bus_f.addr !== 19'd5) begin
                    errors++;
                    $display("FAIL pipe_addr5 got %0d want 5", bus_f.addr);
                end
            end
            if (t == 8) begin
                vectors++;
                if (rgb !== 12'h005) begin
                    errors++;
                    $display("FAIL pipe_rgb5 got %h want 005", rgb);
                end
            end
            tick(1'b1);
        end
    endtask

    task automatic test_sync();
        int low_cnt, first, vs_fall, vs_start;
        logic vs_prev;
        ram_mode = 0;
        do_reset(2);
        low_cnt = 0;
        first = -1;
        vs_fall = -1;
        vs_start = 0;
        vs_prev = 1'b1;
        for (int i = 0; i < 2400; i++) begin
            if (!bus_f.vga_hsync) begin
                if (first < 0) first = t % 800;
                low_cnt++;
            end
            if (t % 800 == 799) begin
                vectors += 2;
                if (low_cnt != 96) begin
                    errors++;
                    $display("FAIL hsync_width line=%0d got %0d want 96", t / 800, low_cnt);
                end
                if (first != 659) begin
                    errors++;
                    $display("FAIL hsync_first line=%0d got %0d want 659", t / 800, first);
                end
                low_cnt = 0;
                first = -1;
            end
            if (vs_prev && !bus_s.vga_vsync) begin
                vectors++;
                if (vs_fall < 0 && t != 260) begin
                    errors++;
                    $display("FAIL vsync_first got %0d want 260", t);
                end
                if (vs_fall >= 0 && t - vs_fall != SFRAME) begin
                    errors++;
                    $display("FAIL vsync_period got %0d want %0d", t - vs_fall, SFRAME);
                end
                vs_fall = t;
                vs_start = t;
            end
            if (!vs_prev && bus_s.vga_vsync) begin
                vectors++;
                if (t - vs_start != SVS * STOT) begin
                    errors++;
                    $display("FAIL vsync_width got %0d want %0d", t - vs_start, SVS * STOT);
                end
            end
            vs_prev = bus_s.vga_vsync;
            tick(1'b1);
        end
    endtask

    task automatic test_frame_scan();
        bit seen [SPIX];
        int n_seen, peak, p, h, v, a;
        exp_t ef, es;
        ram_mode = 2;
        ram_seed = $urandom;
        do_reset(2);
        n_seen = 0;
        peak = -1;
        for (int i = 0; i < SPIX; i++) seen[i] = 1'b0;
        for (int i = 0; i < 2 * SFRAME + 10; i++) begin
            p = t % SFRAME;
            h = p % STOT;
            v = p / STOT;
            a = int'(bus_s.addr);
            if (h < SHA && v < SVA) begin
                vectors++;
                if (a >= SPIX || seen[a]) begin
                    errors++;
                    $display("FAIL scan_unique t=%0d got addr %0d want unused addr < %0d", t, a, SPIX);
                end else begin
                    seen[a] = 1'b1;
                    n_seen++;
                    if (a > peak) peak = a;
                end
            end else if (v >= SVA) begin
                vectors++;
                if (a != 0) begin
                    errors++;
                    $display("FAIL scan_vblank t=%0d got %0d want 0", t, a);
                end
            end
            if (p == SFRAME - 1) begin
                vectors += 2;
                if (n_seen != SPIX) begin
                    errors++;
                    $display("FAIL scan_count got %0d want %0d", n_seen, SPIX);
                end
                if (peak != SPIX - 1) begin
                    errors++;
                    $display("FAIL scan_peak got %0d want %0d", peak, SPIX - 1);
                end
                n_seen = 0;
                peak = -1;
                for (int k = 0; k < SPIX; k++) seen[k] = 1'b0;
            end
            ef = model_full(t);
            es = model_small(t);
            vectors += 2;
            if (obs_f() !== ef) begin
                errors++;
                $display("FAIL scan_full t=%0d got %h want %h", t, obs_f(), ef);
            end
            if (obs_s() !== es) begin
                errors++;
                $display("FAIL scan_small t=%0d got %h want %h", t, obs_s(), es);
            end
            tick(1'b1);
        end
    endtask

    task automatic test_blanking();
        int q, cnt;
        logic [11:0] rgb, want;
        ram_mode = 1;
        do_reset(2);
        cnt = 0;
        for (int i = 0; i < 2 * SFRAME + SLAT + 1; i++) begin
            q = t - SLAT - 1;
            if (q >= 0) begin
                rgb = {bus_s.vga_r, bus_s.vga_g, bus_s.vga_b};
                want = ((q % SFRAME) % STOT < SHA && (q % SFRAME) / STOT < SVA) ? 12'hFFF : 12'h000;
                if (want == 12'hFFF && rgb == 12'hFFF) cnt++;
                vectors++;
                if (rgb !== want) begin
                    errors++;
                    $display("FAIL blank_small t=%0d got %h want %h", t, rgb, want);
                end
                if (q % SFRAME == SFRAME - 1) begin
                    vectors++;
                    if (cnt != SPIX) begin
                        errors++;
                        $display("FAIL blank_count got %0d want %0d", cnt, SPIX);
                    end
                    cnt = 0;
                end
            end
            q = t - FLAT - 1;
            if (q >= 0) begin
                rgb = {bus_f.vga_r, bus_f.vga_g, bus_f.vga_b};
                want = (q % 800 < 640) ? 12'hFFF : 12'h000;
                vectors++;
                if (rgb !== want) begin
                    errors++;
                    $display("FAIL blank_full t=%0d got %h want %h", t, rgb, want);
                end
            end
            tick(1'b1);
        end
    endtask

    task automatic test_midframe_reset();
        int target;
        exp_t e, ef, es, rexp;
        ram_mode = 2;
        ram_seed = $urandom;
        do_reset(2);
        target = int'($urandom_range(1, SVA - 1)) * STOT + int'($urandom_range(0, SHA - 1));
        while (t < target - 1) tick(1'b1);
        tick(1'b0);
        e = model_small(t);
        e.fs = 1'b0;
        vectors++;
        if (obs_s() !== e) begin
            errors++;
            $display("FAIL mid_before t=%0d got %h want %h", t, obs_s(), e);
        end
        tick(1'b1);
        rexp = '{addr: '0, rgb: '0, hs: 1'b1, vs: 1'b1, fs: 1'b1};
        vectors += 2;
        if (obs_s() !== rexp) begin
            errors++;
            $display("FAIL mid_after_small got %h want %h", obs_s(), rexp);
        end
        if (obs_f() !== rexp) begin
            errors++;
            $display("FAIL mid_after_full got %h want %h", obs_f(), rexp);
        end
        for (int i = 0; i < SFRAME + 8; i++) begin
            ef = model_full(t);
            es = model_small(t);
            vectors += 2;
            if (obs_f() !== ef) begin
                errors++;
                $display("FAIL mid_full t=%0d got %h want %h", t, obs_f(), ef);
            end
            if (obs_s() !== es) begin
                errors++;
                $display("FAIL mid_small t=%0d got %h want %h", t, obs_s(), es);
            end
            tick(1'b1);
        end
    endtask

    task automatic test_random();
        int n;
        exp_t ef, es;
        for (int it = 0; it < 4; it++) begin
            ram_mode = 2;
            ram_seed = $urandom;
            do_reset(int'($urandom_range(1, 3)));
            n = int'($urandom_range(200, 1200));
            for (int i = 0; i < n; i++) begin
                ef = model_full(t);
                es = model_small(t);
                ef.fs = ef.fs & rst_n;
                es.fs = es.fs & rst_n;
                vectors += 2;
                if (obs_f() !== ef) begin
                    errors++;
                    $display("FAIL rand_full t=%0d got %h want %h", t, obs_f(), ef);
                end
                if (obs_s() !== es) begin
                    errors++;
                    $display("FAIL rand_small t=%0d got %h want %h", t, obs_s(), es);
                end
                tick(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pipeline();
        test_sync();
        test_frame_scan();
        test_blanking();
        test_midframe_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
